// File: rtl/tanh_share_arbiter.sv
// Round-robin arbiter sharing one pipelined tanh unit between NUM_REQ requesters.
// Optional per-requester statistics are enabled with TANH_SHARE_ARBITER_STATS_EN.
module tanh_share_arbiter #(
    parameter int BITWIDTH     = 18,
    parameter int NUM_REQ      = 4,
    parameter int TANH_LATENCY = 2,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BITWIDTH-1:0]  req_operand,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [BITWIDTH-1:0]          tanh_operand,
    input  logic [BITWIDTH-1:0]          tanh_result,
    output logic                         rsp_valid,
    output logic [BITWIDTH-1:0]          rsp_result,
    output logic [ID_W-1:0]              rsp_id,
    output logic                         busy
`ifdef TANH_SHARE_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]        stat_grants,
    output logic [15:0]                  stat_conflict_cycles
`endif
);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  cand;
    logic             found;
    logic             handshake;

    logic [TANH_LATENCY:0] tag_vld_p;
    logic [ID_W-1:0]       tag_id_p [TANH_LATENCY+1];

    // Scan starts one past the last winner so the previous winner has lowest priority.
    always_comb begin
        req_ready = '0;
        grant_id  = '0;
        cand      = '0;
        found     = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                grant_id = cand;
            end
        end
        if (found && !reset) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign handshake = |(req_valid & req_ready);

    // Stage 0 captures the operand and owner; stages 1..TANH_LATENCY track it through the unit.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr       <= ID_W'(NUM_REQ - 1);
            tanh_operand <= '0;
            tag_vld_p    <= '0;
            for (int s = 0; s <= TANH_LATENCY; s++) begin
                tag_id_p[s] <= '0;
            end
        end else begin
            if (handshake) begin
                tanh_operand <= req_operand[grant_id*BITWIDTH +: BITWIDTH];
                rr_ptr       <= grant_id;
            end
            tag_vld_p   <= {tag_vld_p[TANH_LATENCY-1:0], handshake};
            tag_id_p[0] <= grant_id;
            for (int s = 1; s <= TANH_LATENCY; s++) begin
                tag_id_p[s] <= tag_id_p[s-1];
            end
        end
    end

    assign rsp_valid  = tag_vld_p[TANH_LATENCY];
    assign rsp_id     = tag_id_p[TANH_LATENCY];
    assign rsp_result = tanh_result;
    assign busy       = |tag_vld_p;

`ifdef TANH_SHARE_ARBITER_STATS_EN
    logic [15:0] grant_cnt [NUM_REQ];
    logic [15:0] conflict_cnt;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_cnt <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            if ($countones(req_valid) >= 2 && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && grant_cnt[i] != 16'hFFFF) begin
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grants[i*16 +: 16] = grant_cnt[i];
        end
    end

    assign stat_conflict_cycles = conflict_cnt;
`endif

endmodule
